// File: rtl/hex_display_pkg.sv
// Shared constants and types for the multi-digit hex display driver.
//   SEG_BLANK / SEG_ALL_ON : active-low dark and lamp-test patterns
//   GLYPHS                 : active-low 7-segment patterns for nibbles 0..F
//   state_t                : update sequencer states
package hex_display_pkg;

    localparam logic [6:0] SEG_BLANK  = 7'h7F;
    localparam logic [6:0] SEG_ALL_ON = 7'h00;

    // Entry n is the pattern for nibble n (entry 15 listed first).
    localparam logic [15:0][6:0] GLYPHS = {
        7'h0E, 7'h06, 7'h21, 7'h46,   // F E D C
        7'h03, 7'h08, 7'h10, 7'h00,   // B A 9 8
        7'h78, 7'h02, 7'h12, 7'h19,   // 7 6 5 4
        7'h30, 7'h24, 7'h79, 7'h40    // 3 2 1 0
    };

    typedef enum logic {
        IDLE   = 1'b0,
        UPDATE = 1'b1
    } state_t;

endpackage

// File: rtl/hex_display_bank_glyph.sv
// Combinational hex-nibble to active-low 7-segment glyph lookup.
//   nibble  : hex digit 0..F
//   glyph_c : active-low segment pattern, bit k = segment k
module hex7seg_glyph
    import hex_display_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] glyph_c
);

    always_comb begin
        glyph_c = GLYPHS[nibble];
    end

endmodule

// File: rtl/hex_display_bank.sv
// Multi-digit hex display driver. A load captures the value and masks, then a
// single shared glyph decoder walks the digits from most to least significant,
// one per cycle, applying blanking and leading-zero suppression. The output
// register overlays lamp test and blinking on the stored patterns every cycle.
//   CLOCK_50    : system clock
//   resetn      : synchronous reset, active-low
//   load/ready  : update handshake, load taken only while ready=1
//   value       : packed hex nibbles, digit 0 least significant
//   blank_mask  : per-digit forced dark, captured at load
//   lz_suppress : leading-zero blanking enable, captured at load
//   blink_mask  : per-digit blink enable, live
//   lamp_test   : all segments lit, live
//   HEX         : active-low segments, digit i = HEX[7i+6:7i]
module hex_display_bank
    import hex_display_pkg::*;
#(
    parameter int unsigned DIGITS    = 6,
    parameter int unsigned BLINK_DIV = 25000000
) (
    input  logic                  CLOCK_50,
    input  logic                  resetn,
    input  logic                  load,
    output logic                  ready,
    input  logic [4*DIGITS-1:0]   value,
    input  logic [DIGITS-1:0]     blank_mask,
    input  logic                  lz_suppress,
    input  logic [DIGITS-1:0]     blink_mask,
    input  logic                  lamp_test,
    output logic [7*DIGITS-1:0]   HEX
);

    localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int unsigned CNT_W = $clog2(BLINK_DIV + 1);

    state_t                state, state_next;
    logic [IDX_W-1:0]      idx, idx_next;
    logic                  seen_nz, seen_nz_next;
    logic [4*DIGITS-1:0]   shadow_value;
    logic [DIGITS-1:0]     shadow_blank;
    logic                  shadow_lz;
    logic                  capture;
    logic                  seg_we;
    logic [6:0]            seg_new;
    logic [3:0]            nibble;
    logic                  digit_blank;
    logic [6:0]            glyph_c;
    logic [6:0]            seg_reg [DIGITS];
    logic [CNT_W-1:0]      blink_cnt;
    logic                  blink_phase;
    logic [7*DIGITS-1:0]   hex_next;

    hex7seg_glyph u_glyph (
        .nibble  (nibble),
        .glyph_c (glyph_c)
    );

    // Next-state and per-digit decode for the update walk.
    always_comb begin
        state_next   = state;
        idx_next     = idx;
        seen_nz_next = seen_nz;
        capture      = 1'b0;
        seg_we       = 1'b0;
        seg_new      = SEG_BLANK;
        nibble       = 4'h0;
        digit_blank  = 1'b0;

        for (int i = 0; i < int'(DIGITS); i++) begin
            if (idx == IDX_W'(i)) begin
                nibble      = shadow_value[4*i +: 4];
                digit_blank = shadow_blank[i];
            end
        end

        case (state)
            IDLE: begin
                if (load) begin
                    capture      = 1'b1;
                    idx_next     = IDX_W'(DIGITS - 1);
                    seen_nz_next = 1'b0;
                    state_next   = UPDATE;
                end
            end
            UPDATE: begin
                seg_we = 1'b1;
                if (digit_blank) begin
                    seg_new = SEG_BLANK;
                end else if (shadow_lz && !seen_nz && (nibble == 4'h0) && (idx != '0)) begin
                    seg_new = SEG_BLANK;
                end else begin
                    seg_new = glyph_c;
                end
                // A blanked non-zero digit still ends the leading-zero run.
                if (nibble != 4'h0) begin
                    seen_nz_next = 1'b1;
                end
                if (idx == '0) begin
                    state_next = IDLE;
                end else begin
                    idx_next = idx - IDX_W'(1);
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Sequencer and shadow registers.
    always_ff @(posedge CLOCK_50) begin
        if (!resetn) begin
            state        <= IDLE;
            ready        <= 1'b1;
            idx          <= '0;
            seen_nz      <= 1'b0;
            shadow_value <= '0;
            shadow_blank <= '0;
            shadow_lz    <= 1'b0;
        end else begin
            state   <= state_next;
            ready   <= (state_next == IDLE);
            idx     <= idx_next;
            seen_nz <= seen_nz_next;
            if (capture) begin
                shadow_value <= value;
                shadow_blank <= blank_mask;
                shadow_lz    <= lz_suppress;
            end
        end
    end

    // Stored per-digit patterns; only the digit under idx is written.
    always_ff @(posedge CLOCK_50) begin
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (!resetn) begin
                seg_reg[i] <= SEG_BLANK;
            end else if (seg_we && (idx == IDX_W'(i))) begin
                seg_reg[i] <= seg_new;
            end
        end
    end

    // Free-running blink timer; phase flips each time the counter wraps.
    always_ff @(posedge CLOCK_50) begin
        if (!resetn) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (blink_cnt == CNT_W'(BLINK_DIV - 1)) begin
            blink_cnt   <= '0;
            blink_phase <= ~blink_phase;
        end else begin
            blink_cnt <= blink_cnt + CNT_W'(1);
        end
    end

    // Output overlay: lamp test over blink over stored pattern.
    always_comb begin
        hex_next = {DIGITS{SEG_BLANK}};
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (lamp_test) begin
                hex_next[7*i +: 7] = SEG_ALL_ON;
            end else if (blink_mask[i] && blink_phase) begin
                hex_next[7*i +: 7] = SEG_BLANK;
            end else begin
                hex_next[7*i +: 7] = seg_reg[i];
            end
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (!resetn) begin
            HEX <= {DIGITS{SEG_BLANK}};
        end else begin
            HEX <= hex_next;
        end
    end

endmodule

// File: tb/tb_hex_display_bank.sv
// Directed self-checking bench for hex_display_bank (4 digits, blink divider 4).
module tb_hex_display_bank;

    localparam int unsigned DIGITS    = 4;
    localparam int unsigned BLINK_DIV = 4;

    logic        CLOCK_50 = 1'b0;
    logic        resetn;
    logic        load;
    logic        ready;
    logic [15:0] value;
    logic [3:0]  blank_mask;
    logic        lz_suppress;
    logic [3:0]  blink_mask;
    logic        lamp_test;
    logic [27:0] HEX;

    int n_cmp = 0;
    int n_err = 0;

    hex_display_bank #(
        .DIGITS    (DIGITS),
        .BLINK_DIV (BLINK_DIV)
    ) dut (
        .CLOCK_50    (CLOCK_50),
        .resetn      (resetn),
        .load        (load),
        .ready       (ready),
        .value       (value),
        .blank_mask  (blank_mask),
        .lz_suppress (lz_suppress),
        .blink_mask  (blink_mask),
        .lamp_test   (lamp_test),
        .HEX         (HEX)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    function automatic logic [27:0] pack(input logic [6:0] d3, input logic [6:0] d2,
                                         input logic [6:0] d1, input logic [6:0] d0);
        return {d3, d2, d1, d0};
    endfunction

    // Advance one clock edge, then settle away from it.
    task automatic tick();
        @(posedge CLOCK_50);
        #1;
    endtask

    // Load and let the full update reach HEX (E0 .. E(DIGITS+1)).
    task automatic run_load(input logic [15:0] v, input logic [3:0] bm, input logic lz);
        value       = v;
        blank_mask  = bm;
        lz_suppress = lz;
        load        = 1'b1;
        tick();
        load = 1'b0;
        repeat (DIGITS + 1) tick();
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        tick();
        tick();
        n_cmp++;
        if (HEX !== 28'hFFFFFFF) begin
            n_err++;
            $display("FAIL reset_hex: got %h want %h", HEX, 28'hFFFFFFF);
        end
        n_cmp++;
        if (ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_ready: got %b want 1", ready);
        end
        resetn = 1'b1;
    endtask

    task automatic test_basic();
        value       = 16'h1A3F;
        blank_mask  = 4'b0000;
        lz_suppress = 1'b0;
        load        = 1'b1;
        tick();                                  // E0
        load = 1'b0;
        n_cmp++;
        if (ready !== 1'b0) begin
            n_err++;
            $display("FAIL basic_ready_e0: got %b want 0", ready);
        end
        tick();                                  // E1: digit 3 written, not yet visible
        n_cmp++;
        if (HEX !== 28'hFFFFFFF) begin
            n_err++;
            $display("FAIL basic_hex_e1: got %h want %h", HEX, 28'hFFFFFFF);
        end
        tick();                                  // E2: digit 3 visible
        n_cmp++;
        if (HEX !== pack(7'h79, 7'h7F, 7'h7F, 7'h7F)) begin
            n_err++;
            $display("FAIL basic_hex_e2: got %h want %h", HEX, pack(7'h79, 7'h7F, 7'h7F, 7'h7F));
        end
        tick();                                  // E3
        n_cmp++;
        if (ready !== 1'b0) begin
            n_err++;
            $display("FAIL basic_ready_e3: got %b want 0", ready);
        end
        tick();                                  // E4: digit 0 written, back to idle
        n_cmp++;
        if (HEX !== pack(7'h79, 7'h08, 7'h30, 7'h7F)) begin
            n_err++;
            $display("FAIL basic_hex_e4: got %h want %h", HEX, pack(7'h79, 7'h08, 7'h30, 7'h7F));
        end
        n_cmp++;
        if (ready !== 1'b1) begin
            n_err++;
            $display("FAIL basic_ready_e4: got %b want 1", ready);
        end
        tick();                                  // E5: digit 0 visible
        n_cmp++;
        if (HEX !== pack(7'h79, 7'h08, 7'h30, 7'h0E)) begin
            n_err++;
            $display("FAIL basic_hex_e5: got %h want %h", HEX, pack(7'h79, 7'h08, 7'h30, 7'h0E));
        end
    endtask

    task automatic test_lz();
        run_load(16'h0070, 4'b0000, 1'b1);
        n_cmp++;
        if (HEX !== pack(7'h7F, 7'h7F, 7'h78, 7'h40)) begin
            n_err++;
            $display("FAIL lz_0070: got %h want %h", HEX, pack(7'h7F, 7'h7F, 7'h78, 7'h40));
        end
        run_load(16'h0000, 4'b0000, 1'b1);
        n_cmp++;
        if (HEX !== pack(7'h7F, 7'h7F, 7'h7F, 7'h40)) begin
            n_err++;
            $display("FAIL lz_0000: got %h want %h", HEX, pack(7'h7F, 7'h7F, 7'h7F, 7'h40));
        end
        run_load(16'h0070, 4'b0000, 1'b0);
        n_cmp++;
        if (HEX !== pack(7'h40, 7'h40, 7'h78, 7'h40)) begin
            n_err++;
            $display("FAIL nolz_0070: got %h want %h", HEX, pack(7'h40, 7'h40, 7'h78, 7'h40));
        end
    endtask

    task automatic test_back_to_back();
        value       = 16'h1234;
        blank_mask  = 4'b0000;
        lz_suppress = 1'b0;
        load        = 1'b1;
        tick();                                  // E0 accepts 1234
        value = 16'hFFFF;                        // held load during update must be ignored
        repeat (DIGITS) tick();                  // E1..E4
        n_cmp++;
        if (ready !== 1'b1) begin
            n_err++;
            $display("FAIL b2b_ready_e4: got %b want 1", ready);
        end
        value = 16'h5678;
        tick();                                  // E5 accepts 5678
        load = 1'b0;
        n_cmp++;
        if (ready !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_ready_e5: got %b want 0", ready);
        end
        n_cmp++;
        if (HEX !== pack(7'h79, 7'h24, 7'h30, 7'h19)) begin
            n_err++;
            $display("FAIL b2b_first: got %h want %h", HEX, pack(7'h79, 7'h24, 7'h30, 7'h19));
        end
        repeat (DIGITS + 1) tick();
        n_cmp++;
        if (HEX !== pack(7'h12, 7'h02, 7'h78, 7'h00)) begin
            n_err++;
            $display("FAIL b2b_second: got %h want %h", HEX, pack(7'h12, 7'h02, 7'h78, 7'h00));
        end
        n_cmp++;
        if (ready !== 1'b1) begin
            n_err++;
            $display("FAIL b2b_ready_end: got %b want 1", ready);
        end
    endtask

    task automatic test_blink();
        int          j;
        logic [27:0] exp;
        // Realign the blink timer: phase after edge R+k is (k/4)%2.
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        j = 0;
        run_load(16'h00C5, 4'b0000, 1'b0);
        j = j + DIGITS + 2;
        blink_mask = 4'b0001;
        for (int c = 0; c < 12; c++) begin
            tick();
            j++;
            if ((((j - 1) / 4) % 2) == 1) exp = pack(7'h40, 7'h40, 7'h46, 7'h7F);
            else                          exp = pack(7'h40, 7'h40, 7'h46, 7'h12);
            n_cmp++;
            if (HEX !== exp) begin
                n_err++;
                $display("FAIL blink_c%0d: got %h want %h", c, HEX, exp);
            end
        end
        lamp_test = 1'b1;
        for (int c = 0; c < 5; c++) begin
            tick();
            n_cmp++;
            if (HEX !== 28'h0000000) begin
                n_err++;
                $display("FAIL lamp_c%0d: got %h want %h", c, HEX, 28'h0000000);
            end
        end
        lamp_test  = 1'b0;
        blink_mask = 4'b0000;
        tick();
        n_cmp++;
        if (HEX !== pack(7'h40, 7'h40, 7'h46, 7'h12)) begin
            n_err++;
            $display("FAIL lamp_off: got %h want %h", HEX, pack(7'h40, 7'h40, 7'h46, 7'h12));
        end
    endtask

    task automatic test_blank();
        run_load(16'h0800, 4'b0100, 1'b1);
        n_cmp++;
        if (HEX !== pack(7'h7F, 7'h7F, 7'h40, 7'h40)) begin
            n_err++;
            $display("FAIL blank_0800: got %h want %h", HEX, pack(7'h7F, 7'h7F, 7'h40, 7'h40));
        end
    endtask

    task automatic test_reset_mid();
        value       = 16'h1A3F;
        blank_mask  = 4'b0000;
        lz_suppress = 1'b0;
        load        = 1'b1;
        tick();                                  // E0
        load = 1'b0;
        tick();                                  // E1
        resetn = 1'b0;
        tick();                                  // E2 is a reset edge
        n_cmp++;
        if (HEX !== 28'hFFFFFFF) begin
            n_err++;
            $display("FAIL midrst_hex: got %h want %h", HEX, 28'hFFFFFFF);
        end
        n_cmp++;
        if (ready !== 1'b1) begin
            n_err++;
            $display("FAIL midrst_ready: got %b want 1", ready);
        end
        resetn = 1'b1;
        repeat (3) tick();
        n_cmp++;
        if (HEX !== 28'hFFFFFFF) begin
            n_err++;
            $display("FAIL midrst_nopartial: got %h want %h", HEX, 28'hFFFFFFF);
        end
        run_load(16'h1A3F, 4'b0000, 1'b0);
        n_cmp++;
        if (HEX !== pack(7'h79, 7'h08, 7'h30, 7'h0E)) begin
            n_err++;
            $display("FAIL midrst_reload: got %h want %h", HEX, pack(7'h79, 7'h08, 7'h30, 7'h0E));
        end
    endtask

    initial begin
        resetn      = 1'b0;
        load        = 1'b0;
        value       = 16'h0000;
        blank_mask  = 4'b0000;
        lz_suppress = 1'b0;
        blink_mask  = 4'b0000;
        lamp_test   = 1'b0;

        test_reset();
        test_basic();
        test_lz();
        test_back_to_back();
        test_blink();
        test_blank();
        test_reset_mid();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
